senone_score_scheduler: RTL and testbench

Frame-level sequencer for the senone scoring back end. On each `start` it clears the shared max unit and streams every senone score from score RAM into it. It captures the frame's best score, then runs a second pass over the RAM that writes back each score normalised against the best. It sits between the acoustic-scoring pipeline, which fills the RAM, and the search stage, which consumes the normalised scores after `done`.

---
 rtl/senone_score_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_senone_score_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/senone_score_scheduler.sv
// Frame sequencer for senone scoring: scans score RAM through the shared max unit,
// captures the frame best, then rewrites each score normalised against that best.
module senone_score_scheduler #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_senone_count,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [15:0]       i_rd_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_max_clear,
  output logic              o_max_new_senone,
  output logic              o_max_last_senone,
  output logic [15:0]       o_max_score,
  input  logic [15:0]       i_max_best,
  input  logic              i_max_done,
  output logic [15:0]       o_best_score,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DATA_W = 16;
  localparam logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(1) << ADDR_W;
  localparam logic [DATA_W-1:0] MOST_NEG  = 16'h8000;
  localparam logic [DATA_W-1:0] MOST_POS  = 16'h7FFF;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_NORM, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_max_clear;
  logic                r_max_new;
  logic                r_max_last;
  logic [DATA_W-1:0]   r_best;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic [CNT_W-1:0]    w_count_clamped;
  logic [ADDR_W-1:0]   w_last_addr;
  logic                w_at_last;
  logic                w_rd_en_nxt;
  logic [ADDR_W-1:0]   w_rd_addr_nxt;
  logic                w_max_clear_nxt;
  logic [DATA_W-1:0]   w_best_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic signed [DATA_W:0] w_diff;
  logic [DATA_W-1:0]   w_norm;

  assign w_accept        = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_count_clamped = (i_senone_count > MAX_COUNT) ? MAX_COUNT : i_senone_count;
  assign w_last_addr     = ADDR_W'(r_count - CNT_W'(1));
  assign w_at_last       = (r_rd_addr == w_last_addr);

  // 17-bit signed difference against the frame best, saturated to 16 bits
  assign w_diff = $signed({i_rd_data[DATA_W-1], i_rd_data}) - $signed({r_best[DATA_W-1], r_best});

  always_comb begin
    w_norm = w_diff[DATA_W-1:0];
    if (w_diff[DATA_W] != w_diff[DATA_W-1]) begin
      w_norm = w_diff[DATA_W] ? MOST_NEG : MOST_POS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NORM holds one extra cycle with no read so the trailing write completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          w_state_nxt = (w_count_clamped == '0) ? S_NORM : S_SCAN;
        end
      end
      S_SCAN:  if (w_at_last)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (i_max_done) w_state_nxt = S_NORM;
      S_NORM:  if (!r_rd_en)   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en_nxt     = 1'b0;
    w_rd_addr_nxt   = '0;
    w_max_clear_nxt = 1'b0;
    w_best_nxt      = r_best;
    w_count_nxt     = r_count;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_max_clear_nxt = 1'b1;
          w_best_nxt      = MOST_NEG;
          w_count_nxt     = w_count_clamped;
          w_rd_en_nxt     = (w_count_clamped != '0);
        end
      end
      S_SCAN: begin
        if (!w_at_last) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (i_max_done) begin
          w_best_nxt  = i_max_best;
          w_rd_en_nxt = 1'b1;
        end
      end
      S_NORM: begin
        if (r_rd_en && !w_at_last) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_max_clear <= 1'b0;
      r_max_new   <= 1'b0;
      r_max_last  <= 1'b0;
      r_best      <= MOST_NEG;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_wr_en     <= (r_state == S_NORM) && r_rd_en;
      r_wr_addr   <= ((r_state == S_NORM) && r_rd_en) ? r_rd_addr : '0;
      r_max_clear <= w_max_clear_nxt;
      r_max_new   <= (r_state == S_SCAN) && r_rd_en;
      r_max_last  <= (r_state == S_SCAN) && r_rd_en && w_at_last;
      r_best      <= w_best_nxt;
      r_busy      <= (w_state_nxt == S_SCAN) || (w_state_nxt == S_DRAIN) || (w_state_nxt == S_NORM);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // RAM read data passes straight through, gated so idle values stay at zero
  assign o_max_score       = r_max_new ? i_rd_data : '0;
  assign o_wr_data         = r_wr_en ? w_norm : '0;
  assign o_rd_en           = r_rd_en;
  assign o_rd_addr         = r_rd_addr;
  assign o_wr_en           = r_wr_en;
  assign o_wr_addr         = r_wr_addr;
  assign o_max_clear       = r_max_clear;
  assign o_max_new_senone  = r_max_new;
  assign o_max_last_senone = r_max_last;
  assign o_best_score      = r_best;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: tb/tb_senone_score_scheduler.sv
// Bench for senone_score_scheduler: score RAM and max unit models, directed frame vectors.
module tb_senone_score_scheduler;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   senone_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              max_clear;
  logic              max_new;
  logic              max_last;
  logic [15:0]       max_score;
  logic [15:0]       max_best;
  logic              max_done;
  logic [15:0]       best_score;
  logic              busy;
  logic              done;

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_data;
  logic [15:0]       mem     [DEPTH];
  logic [15:0]       img     [DEPTH];
  logic [15:0]       exp_mem [DEPTH];

  int n_checks;
  int n_errors;

  senone_score_scheduler #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_senone_count(senone_count),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_max_clear(max_clear), .o_max_new_senone(max_new), .o_max_last_senone(max_last),
    .o_max_score(max_score), .i_max_best(max_best), .i_max_done(max_done),
    .o_best_score(best_score), .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Score RAM: one-cycle read latency, plus a bench-side load port
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Max unit: signed running max, cleared by reset or max_clear
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      max_best <= 16'h8000;
      max_done <= 1'b0;
    end else begin
      max_done <= max_last;
      if (max_clear) max_best <= 16'h8000;
      else if (max_new && ($signed(max_score) > $signed(max_best))) max_best <= max_score;
    end
  end

  typedef struct {
    int          cnt;
    logic [15:0] init [4];
    logic [15:0] exp_best;
    logic [15:0] exp_ram [4];
    int          restart_k;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s.strobes", tag), 32'({rd_en, wr_en, max_clear, max_new, max_last, busy, done}), 32'h0);
    check($sformatf("%s.addrs", tag), 32'({rd_addr, wr_addr}), 32'h0);
    check($sformatf("%s.data", tag), {max_score, wr_data}, 32'h0);
    check($sformatf("%s.best", tag), 32'(best_score), 32'h8000);
  endtask

  task automatic load_img();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = ADDR_W'(i);
      ld_data = img[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s.ram[%0d]", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    end
  endtask

  // Called just after a falling edge; start is high during cycle T (k=0)
  task automatic run_frame(input string tag, input int cnt, input int n_eff,
                           input logic [15:0] exp_best, input int restart_k);
    int k, done_k, done_n, clear_n, rd_n, wr_n, new_n, last_k, last_n, conflicts, exp_done, best_k;
    exp_done = (n_eff == 0) ? 2 : 2 * n_eff + 4;
    best_k   = (n_eff == 0) ? 1 : n_eff + 3;
    done_k = -1; last_k = -1;
    done_n = 0; clear_n = 0; rd_n = 0; wr_n = 0; new_n = 0; last_n = 0; conflicts = 0;
    k = 0;
    start = 1'b1;
    senone_count = CNT_W'(cnt);
    while (k < exp_done + 8 && !(done_k >= 0 && k >= done_k + 3)) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check($sformatf("%s.clear_t1", tag), 32'(max_clear), 32'h1);
        if (n_eff > 0) check($sformatf("%s.busy_t1", tag), 32'(busy), 32'h1);
      end
      if (max_clear) clear_n++;
      if (rd_en) rd_n++;
      if (wr_en) wr_n++;
      if (max_new) new_n++;
      if (max_last) begin last_n++; last_k = k; end
      if (rd_en && wr_en && rd_addr == wr_addr) conflicts++;
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          check($sformatf("%s.busy_at_done", tag), 32'(busy), 32'h0);
        end
      end
      if (k == best_k) check($sformatf("%s.best_early", tag), 32'(best_score), 32'(exp_best));
      start = (k == restart_k);
      senone_count = (k == restart_k) ? CNT_W'(1) : CNT_W'(cnt);
    end
    start = 1'b0;
    check($sformatf("%s.done_cycle", tag), done_k, exp_done);
    check($sformatf("%s.done_pulses", tag), done_n, 1);
    check($sformatf("%s.clear_pulses", tag), clear_n, 1);
    check($sformatf("%s.reads", tag), rd_n, 2 * n_eff);
    check($sformatf("%s.writes", tag), wr_n, n_eff);
    check($sformatf("%s.samples", tag), new_n, n_eff);
    check($sformatf("%s.last_cycle", tag), last_k, (n_eff > 0) ? n_eff + 1 : -1);
    check($sformatf("%s.last_pulses", tag), last_n, (n_eff > 0) ? 1 : 0);
    check($sformatf("%s.addr_conflicts", tag), conflicts, 0);
    check($sformatf("%s.best_final", tag), 32'(best_score), 32'(exp_best));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start = 1'b0;
    senone_count = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    vecs[0] = '{4, '{16'hFF9C, 16'h0032, 16'hFFFD, 16'h0032}, 16'h0032,
                '{16'hFF6A, 16'h0000, 16'hFFCB, 16'h0000}, -1};
    vecs[1] = '{1, '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h8000,
                '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, -1};
    vecs[2] = '{2, '{16'h7FFF, 16'h8000, 16'h1111, 16'h2222}, 16'h7FFF,
                '{16'h0000, 16'h8000, 16'h0000, 16'h0000}, -1};
    vecs[3] = '{0, '{16'h7FFF, 16'h0005, 16'h0006, 16'h0007}, 16'h8000,
                '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, -1};
    vecs[4] = '{3, '{16'hFFFB, 16'hFFF9, 16'hFFFE, 16'h7000}, 16'hFFFE,
                '{16'hFFFD, 16'hFFFB, 16'h0000, 16'h0000}, -1};
    vecs[5] = '{4, '{16'hFF9C, 16'h0032, 16'hFFFD, 16'h0032}, 16'h0032,
                '{16'hFF6A, 16'h0000, 16'hFFCB, 16'h0000}, 3};

    repeat (2) @(negedge clk);
    check_reset_values("init");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < DEPTH; i++) img[i] = 16'h0A00 + 16'(i);
      for (int j = 0; j < 4; j++) img[j] = vecs[v].init[j];
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = img[i];
      for (int j = 0; j < vecs[v].cnt; j++) exp_mem[j] = vecs[v].exp_ram[j];
      load_img();
      run_frame($sformatf("v%0d", v), vecs[v].cnt, vecs[v].cnt, vecs[v].exp_best, vecs[v].restart_k);
      check_ram($sformatf("v%0d", v));
    end

    // Oversized count clamps to the full RAM depth
    for (int i = 0; i < DEPTH; i++) begin
      img[i]     = 16'(i * 10 - 100);
      exp_mem[i] = 16'(i * 10 - 150);
    end
    load_img();
    run_frame("clamp", 20, 16, 16'h0032, -1);
    check_ram("clamp");

    // Reset in the middle of a scan, then a fresh frame
    for (int i = 0; i < DEPTH; i++) img[i] = 16'h0B00 + 16'(i);
    img[0] = 16'd10; img[1] = 16'hFFEC; img[2] = 16'd35; img[3] = 16'd5;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = img[i];
    exp_mem[0] = 16'hFFE7; exp_mem[1] = 16'hFFC9; exp_mem[2] = 16'h0000; exp_mem[3] = 16'hFFE2;
    load_img();
    start = 1'b1;
    senone_count = CNT_W'(8);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame("after_rst", 4, 4, 16'd35, -1);
    check_ram("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
